alu32_result_stage: RTL and testbench
=====================================

Name: alu32_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit bitwise/arithmetic units (Or32, And32, Xor32, FullAdder32).
- Each cycle the units present parallel results. This block selects one by opcode, derives condition flags and registers the result.
- A 2-entry skid buffer with valid/ready handshake isolates the combinational ALU from the writeback/consumer side.

Parameters:
- WIDTH, 32, datapath width; all result ports are this width.
- OPW, 3, opcode width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result set valid this cycle
- in_ready  output  1  stage can accept a result set
- op  input  OPW  operation select
- and_res  input  WIDTH  And32 output
- or_res  input  WIDTH  Or32 output
- xor_res  input  WIDTH  Xor32 output
- sum_res  input  WIDTH  FullAdder32 sum (ADD or SUB configured upstream)
- sum_cout  input  1  FullAdder32 carry-out
- out_valid  output  1  registered result available
- out_ready  input  1  consumer accepts result
- out_res  output  WIDTH  selected result
- out_z  output  1  zero flag
- out_n  output  1  negative flag (out_res[WIDTH-1])
- out_c  output  1  carry flag
- out_err  output  1  illegal opcode flag

Behaviour:
- Opcode selection (evaluated at acceptance):
  - 0 AND → and_res, C=0
  - 1 OR → or_res, C=0
  - 2 XOR → xor_res, C=0
  - 3 ADD → sum_res, C=sum_cout
  - 4 SUB → sum_res, C=sum_cout (carry = not-borrow)
  - 5..7 → result 0, C=0, err=1
- Z = (selected result == 0), including illegal ops (Z=1). N = result MSB.
- Acceptance: transfer on in_valid && in_ready. Emission: transfer on out_valid && out_ready.
- Storage: main output register plus one skid register; the whole packed entry {res,z,n,c,err} is stored.
- in_ready is registered and equals !skid_full. It is never combinationally dependent on out_ready.
- Latency: 1 cycle. An accepted set appears on out_* the next cycle when the main register is empty or draining.
- State (occupancy): EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY + accept → ONE
  - ONE + accept & emit → ONE (main reloads with new entry)
  - ONE + accept & !emit → TWO (new entry to skid, in_ready drops next cycle)
  - ONE + emit & !accept → EMPTY
  - TWO + emit → ONE (skid moves to main, in_ready rises next cycle)
  - TWO never accepts.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- out_* stay stable while out_valid && !out_ready.
- Inputs are ignored when !in_valid or !in_ready.
- Reset (async assert, sync deassert by the system):
  - out_valid=0, in_ready=1, out_res=0, out_z=0, out_n=0, out_c=0, out_err=0, skid cleared.
  - Reset mid-transfer discards all held entries.
- out_z/out_n/out_c/out_err are meaningful only when out_valid=1.

Optional Feature:
- Macro ALU32_RESULT_STATS_EN.
- Defined:
  - Adds outputs stat_count [15:0] (results emitted) and stat_err [15:0] (illegal-op results emitted).
  - Both increment on the emit handshake and saturate at 16'hFFFF.
  - Reset to 0.
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- OR pass-through: rst_n released, op=1, or_res=32'hF0F0_0000, in_valid=1, out_ready=1 → next cycle out_valid=1, out_res=32'hF0F0_0000, z=0, n=1, c=0, err=0.
- ADD carry/zero: op=3, sum_res=0, sum_cout=1 → out_res=0, z=1, c=1, n=0.
- Backpressure: out_ready=0, stream op=0 with and_res=1,2,3 back to back.
  - Required: results 1 and 2 accepted, in_ready=0 from the cycle after the second accept, 3 held upstream.
  - Raising out_ready delivers 1,2,3 in order with no gaps after the first.
- Illegal op: op=6, valid data on all inputs → out_res=0, err=1, z=1, c=0.
- Reset mid-operation: fill TWO state, assert rst_n=0 asynchronously mid-cycle → out_valid=0 and in_ready=1 immediately. After release, no stale entry is emitted.
- Stats (ALU32_RESULT_STATS_EN): emit 3 legal + 2 illegal → stat_count=5, stat_err=2. Preload saturation via 65540 emits → stat_count=16'hFFFF.

Source files
------------

// File: rtl/alu32_result_stage.sv
// ALU result output stage: opcode select, flag derivation, 2-entry skid buffer.
// Optional emit statistics counters enabled by defining ALU32_RESULT_STATS_EN.
module alu32_result_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] sum_res,
    input  logic             sum_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_err
`ifdef ALU32_RESULT_STATS_EN
    ,
    output logic [15:0]      stat_count,
    output logic [15:0]      stat_err
`endif
);

    localparam int EW = WIDTH + 4;

    localparam logic [OPW-1:0] OP_AND = OPW'(0);
    localparam logic [OPW-1:0] OP_OR  = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4);

    // Packed entry layout: {res, z, n, c, err}
    function automatic logic [EW-1:0] build_entry(
        input logic [OPW-1:0]   f_op,
        input logic [WIDTH-1:0] f_and,
        input logic [WIDTH-1:0] f_or,
        input logic [WIDTH-1:0] f_xor,
        input logic [WIDTH-1:0] f_sum,
        input logic             f_cout
    );
        logic [WIDTH-1:0] r;
        logic             c;
        logic             e;
        r = '0;
        c = 1'b0;
        e = 1'b0;
        case (f_op)
            OP_AND:         r = f_and;
            OP_OR:          r = f_or;
            OP_XOR:         r = f_xor;
            OP_ADD, OP_SUB: begin
                r = f_sum;
                c = f_cout;
            end
            default:        e = 1'b1;
        endcase
        return {r, (r == '0), r[WIDTH-1], c, e};
    endfunction

    // Stage 0: combinational selection of the incoming result set
    logic [EW-1:0] ent_p0;
    logic          accept;
    logic          emit;

    logic [EW-1:0] ent_p1;
    logic          vld_p1;
    logic [EW-1:0] skid_p1;
    logic          skid_vld_p1;

    assign ent_p0 = build_entry(op, and_res, or_res, xor_res, sum_res, sum_cout);
    assign accept = in_valid && in_ready;
    assign emit   = vld_p1 && out_ready;

    // Stage 1: main output register plus skid entry; skid is only filled while main stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ent_p1      <= '0;
            skid_p1     <= '0;
        end else if (emit) begin
            if (skid_vld_p1) begin
                ent_p1      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end else if (accept) begin
                ent_p1 <= ent_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            if (!vld_p1) begin
                ent_p1 <= ent_p0;
                vld_p1 <= 1'b1;
            end else begin
                skid_p1     <= ent_p0;
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    // in_ready comes straight from the skid flop, so it never sees out_ready combinationally
    assign in_ready  = !skid_vld_p1;
    assign out_valid = vld_p1;
    assign {out_res, out_z, out_n, out_c, out_err} = ent_p1;

`ifdef ALU32_RESULT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= 16'd0;
            stat_err   <= 16'd0;
        end else if (emit) begin
            if (stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
            if (ent_p1[0] && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu32_result_stage.sv
// Randomized bench for alu32_result_stage against a queue-based reference model.
module tb_alu32_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] and_res = '0, or_res = '0, xor_res = '0, sum_res = '0;
    logic        sum_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic        out_z, out_n, out_c, out_err;
`ifdef ALU32_RESULT_STATS_EN
    logic [15:0] stat_count, stat_err;
`endif

    int checks = 0;
    int failures = 0;

    alu32_result_stage #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .sum_res(sum_res), .sum_cout(sum_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_err(out_err)
`ifdef ALU32_RESULT_STATS_EN
        , .stat_count(stat_count), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result/flags per opcode rules, packed as {res, z, n, c, err}
    function automatic logic [35:0] model_entry(input int o, input logic [31:0] a, input logic [31:0] orv,
                                                input logic [31:0] x, input logic [31:0] s, input logic co);
        logic [31:0] r;
        logic        c;
        logic        e;
        r = 32'd0;
        c = 1'b0;
        e = 1'b0;
        if (o == 0) r = a;
        else if (o == 1) r = orv;
        else if (o == 2) r = x;
        else if (o == 3 || o == 4) begin
            r = s;
            c = co;
        end else e = 1'b1;
        return {r, (r == 32'd0), r[31], c, e};
    endfunction

    logic [35:0] q[$];
    int          n_emit = 0;
    int          n_err = 0;
    logic [35:0] cmp_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            n_emit = 0;
            n_err = 0;
        end else begin
            automatic bit do_emit = (q.size() > 0) && out_ready;
            automatic bit do_acc  = in_valid && (q.size() < 2);
            if (do_emit) begin
                n_emit++;
                if (q[0][0]) n_err++;
                void'(q.pop_front());
            end
            if (do_acc) q.push_back(model_entry(int'(op), and_res, or_res, xor_res, sum_res, sum_cout));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                cmp_e = q[0];
                chk("out_res", out_res, cmp_e[35:4]);
                chk("out_z", 32'(out_z), 32'(cmp_e[3]));
                chk("out_n", 32'(out_n), 32'(cmp_e[2]));
                chk("out_c", 32'(out_c), 32'(cmp_e[1]));
                chk("out_err", 32'(out_err), 32'(cmp_e[0]));
            end
`ifdef ALU32_RESULT_STATS_EN
            chk("stat_count", 32'(stat_count), (n_emit > 65535) ? 32'hFFFF : 32'(n_emit));
            chk("stat_err", 32'(stat_err), (n_err > 65535) ? 32'hFFFF : 32'(n_err));
`endif
        end
    end

    initial begin
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // OR pass-through
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd1; or_res = 32'hF0F0_0000;
        @(negedge clk);
        chk("or_valid", 32'(out_valid), 32'd1);
        chk("or_res", out_res, 32'hF0F0_0000);
        chk("or_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'b0100);
        op = 3'd3; sum_res = 32'd0; sum_cout = 1'b1;
        @(negedge clk);
        chk("add_res", out_res, 32'd0);
        chk("add_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'b1010);
        op = 3'd6; and_res = 32'h1234_5678; or_res = 32'hFFFF_0001; xor_res = 32'h8000_0000;
        sum_res = 32'hDEAD_BEEF; sum_cout = 1'b1;
        @(negedge clk);
        chk("ill_res", out_res, 32'd0);
        chk("ill_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'b1001);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; and_res = 32'd1;
        @(negedge clk);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        and_res = 32'd2;
        @(negedge clk);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        and_res = 32'd3;
        repeat (2) @(negedge clk);
        chk("bp_stall_res", out_res, 32'd1);
        chk("bp_stall_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", out_res, 32'd2);
        @(negedge clk);
        chk("bp_third", out_res, 32'd3);
        chk("bp_third_vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset while holding two entries
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; xor_res = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("full_rdy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 3'($urandom_range(0, 7));
            and_res   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            or_res    = $urandom;
            xor_res   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            sum_res   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            sum_cout  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rand_drained", 32'(out_valid), 32'd0);

`ifdef ALU32_RESULT_STATS_EN
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("stat_rst", 32'(stat_count), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : (i == 2) ? 3'd3 : (i == 3) ? 3'd5 : 3'd7;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stat_count5", 32'(stat_count), 32'd5);
        chk("stat_err2", 32'(stat_err), 32'd2);
        in_valid = 1'b1; op = 3'd0;
        repeat (65540) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stat_sat", 32'(stat_count), 32'hFFFF);
        chk("stat_err_hold", 32'(stat_err), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
